// File: rtl/ray_frame_dispatcher.sv
// Ray-issuing side of the box tracer: scans the frame, issues one ray per pixel, shades
// each returned hit and writes it to the framebuffer through a credit-protected result FIFO.
module ray_frame_dispatcher #(
  parameter int          H_RES      = 64,
  parameter int          V_RES      = 48,
  parameter int          ADDR_W     = 12,
  parameter int          TRACE_LAT  = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [8:0]  FOCAL      = 9'd256,
  parameter logic [11:0] BG_COLOR   = 12'h013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [27:0]       cam_pos,
  output logic              busy,
  output logic              done,
  output logic              ray_valid,
  output logic [27:0]       init,
  output logic [30:0]       dir,
  input  logic [9:0]        t_in,
  input  logic [30:0]       normal_in,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [11:0]       fb_data,
  output logic              fb_we,
  input  logic              fb_ready
);

  localparam int COL_W = $clog2(H_RES);
  localparam int ROW_W = $clog2(V_RES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CRD_W = $clog2(FIFO_DEPTH + TRACE_LAT + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_pix_addr;
  logic [27:0]       r_cam;
  logic [TRACE_LAT-1:0] r_tag_v;
  logic [ADDR_W-1:0] r_tag_addr [TRACE_LAT];
  logic [CRD_W-1:0]  r_in_flight;
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [11:0]       r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_push, w_pop, w_issue, w_last;
  logic [CRD_W-1:0]  w_credit;
  logic [10:0]       w_dx, w_dy;
  logic [10:0]       w_nx, w_ny, w_ax, w_ay, w_az;
  logic [3:0]        w_int;
  logic [11:0]       w_shade;

  // A pop this cycle frees its slot for the ray issued this cycle.
  assign w_push    = r_tag_v[TRACE_LAT-1];
  assign fb_we     = (r_count != '0);
  assign w_pop     = fb_we & fb_ready;
  assign w_credit  = r_in_flight + CRD_W'(r_count) - CRD_W'(w_pop);
  assign w_issue   = (r_state == S_ISSUE) && (w_credit < CRD_W'(FIFO_DEPTH));
  assign w_last    = (r_col == COL_W'(H_RES - 1)) && (r_row == ROW_W'(V_RES - 1));

  assign w_dx      = 11'(r_col) - 11'(H_RES / 2);
  assign w_dy      = 11'(V_RES / 2 - 1) - 11'(r_row);
  assign ray_valid = w_issue;
  assign dir       = w_issue ? {w_dx, w_dy, FOCAL} : '0;
  assign init      = r_cam;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign fb_addr   = fb_we ? r_fifo_addr[r_rd_ptr] : '0;
  assign fb_data   = fb_we ? r_fifo_data[r_rd_ptr] : '0;

  always_comb begin
    w_nx    = normal_in[30:20];
    w_ny    = normal_in[19:9];
    w_ax    = w_nx[10] ? (~w_nx + 11'd1) : w_nx;
    w_ay    = w_ny[10] ? (~w_ny + 11'd1) : w_ny;
    w_az    = {2'b00, normal_in[8:0]};
    w_int   = 4'hF - t_in[9:6];
    if (w_int == 4'h0) w_int = 4'h1;
    w_shade = {8'h00, w_int};
    if (t_in == 10'h3FF)                   w_shade = BG_COLOR;
    else if (w_ax >= w_ay && w_ax >= w_az) w_shade = {w_int, 8'h00};
    else if (w_ay >= w_az)                 w_shade = {4'h0, w_int, 4'h0};
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_ISSUE;
      S_ISSUE: if (w_issue && w_last) w_state_next = S_DRAIN;
      S_DRAIN: if (r_in_flight == '0 && r_count == '0) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_pix_addr <= '0;
      r_cam      <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_col      <= '0;
      r_row      <= '0;
      r_pix_addr <= '0;
      r_cam      <= cam_pos;
    end else if (w_issue) begin
      r_pix_addr <= r_pix_addr + ADDR_W'(1);
      if (r_col == COL_W'(H_RES - 1)) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Tag pipe mirrors the tracer latency so each result arrives with its pixel address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag_v     <= '0;
      r_in_flight <= '0;
      for (int k = 0; k < TRACE_LAT; k++) r_tag_addr[k] <= '0;
    end else begin
      r_tag_v[0]    <= w_issue;
      r_tag_addr[0] <= r_pix_addr;
      for (int k = 1; k < TRACE_LAT; k++) begin
        r_tag_v[k]    <= r_tag_v[k-1];
        r_tag_addr[k] <= r_tag_addr[k-1];
      end
      r_in_flight <= r_in_flight + CRD_W'(w_issue) - CRD_W'(w_push);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // On a full FIFO the head is read combinationally before this write replaces it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= r_tag_addr[TRACE_LAT-1];
      r_fifo_data[r_wr_ptr] <= w_shade;
    end
  end

endmodule
